// File: rtl/score_bcd_if.sv
// score_bcd_if: score input, start request and BCD display result bundle
interface score_bcd_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [WIDTH-1:0]      score;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    modport master (output start, score, input bcd, blank, busy, done, overflow);
    modport slave  (input start, score, output bcd, blank, busy, done, overflow);
endinterface

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: one-bit-per-clock double-dabble score to BCD with blank mask
module score_bcd_converter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8,
    parameter int AUTO   = 1
) (
    input logic         clk,
    input logic         rst,
    score_bcd_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    function automatic logic [63:0] max_val(input int d);
        logic [63:0] v;
        v = 64'd1;
        for (int k = 0; k < d; k++) v = v * 64'd10;
        return v - 64'd1;
    endfunction
    localparam logic [63:0] MAXV = max_val(DIGITS);
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    state_t            state;
    logic [BW-1:0]     acc;
    logic [BW-1:0]     adj;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  snap;
    logic [CW-1:0]     cnt;
    logic              ovf;
    logic              sat;
    logic              trig;
    logic [DIGITS-1:0] nxt_blank;
    assign sat  = 64'(bus.score) > MAXV;
    assign trig = bus.start || (AUTO != 0 && bus.score != snap);
    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
        assign adj[4*i+:4] = acc[4*i+:4] >= 4'd5 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
        if (i == 0) begin : g_lsd
            assign nxt_blank[i] = 1'b0;
        end else begin : g_upper
            assign nxt_blank[i] = ~|acc[BW-1:4*i];
        end
    end
    // One extra CONVERT cycle after the last shift keeps done at WIDTH+2 edges after the trigger
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            snap         <= '0;
            cnt          <= '0;
            acc          <= '0;
            sr           <= '0;
            ovf          <= 1'b0;
            bus.bcd      <= '0;
            bus.blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (trig) begin
                    snap     <= bus.score;
                    sr       <= sat ? MAXV[WIDTH-1:0] : bus.score;
                    ovf      <= sat;
                    acc      <= '0;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                    state    <= CONVERT;
                end
                CONVERT: if (cnt == CW'(WIDTH)) begin
                    state <= COMMIT;
                end else begin
                    {acc, sr} <= {adj[BW-2:0], sr, 1'b0};
                    cnt       <= cnt + CW'(1);
                end
                COMMIT: begin
                    bus.bcd      <= acc;
                    bus.blank    <= nxt_blank;
                    bus.overflow <= ovf;
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter: directed checks of latency, digits, blanking, overflow and reset abort
module tb_score_bcd_converter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    score_bcd_if #(.WIDTH(32), .DIGITS(8)) bus ();
    score_bcd_converter #(.WIDTH(32), .DIGITS(8), .AUTO(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #10 clk = ~clk;
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 200);
        if (!bus.done) n = -1;
    endtask
    task automatic test_reset();
        int seen;
        bus.start = 1'b0;
        bus.score = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.bcd !== 32'h0) begin failures++; $display("FAIL reset_bcd got %h want %h", bus.bcd, 32'h0); end
        checks++; if (bus.blank !== 8'hFE) begin failures++; $display("FAIL reset_blank got %h want %h", bus.blank, 8'hFE); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL idle_zero_activity got %0d want 0", seen); end
        checks++; if (bus.blank !== 8'hFE) begin failures++; $display("FAIL idle_blank got %h want %h", bus.blank, 8'hFE); end
    endtask
    task automatic test_latency();
        int n;
        @(negedge clk);
        bus.score = 32'd12345678;
        @(posedge clk);
        wait_done(n);
        checks++; if (n !== 34) begin failures++; $display("FAIL latency got %0d want 34", n); end
        checks++; if (bus.bcd !== 32'h12345678) begin failures++; $display("FAIL bcd_12345678 got %h want %h", bus.bcd, 32'h12345678); end
        checks++; if (bus.blank !== 8'h00) begin failures++; $display("FAIL blank_12345678 got %h want %h", bus.blank, 8'h00); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_12345678 got %b want 0", bus.overflow); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_at_done got %b want 0", bus.busy); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got %b want 0", bus.done); end
    endtask
    task automatic test_values();
        int n;
        @(negedge clk);
        bus.score = 32'd305;
        wait_done(n);
        checks++; if (bus.bcd !== 32'h00000305 || n < 0) begin failures++; $display("FAIL bcd_305 got %h want %h", bus.bcd, 32'h305); end
        checks++; if (bus.blank !== 8'hF8) begin failures++; $display("FAIL blank_305 got %h want %h", bus.blank, 8'hF8); end
        @(negedge clk);
        bus.score = 32'd99999999;
        wait_done(n);
        checks++; if (bus.bcd !== 32'h99999999 || n < 0) begin failures++; $display("FAIL bcd_max got %h want %h", bus.bcd, 32'h99999999); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_max got %b want 0", bus.overflow); end
    endtask
    task automatic test_overflow();
        int n;
        @(negedge clk);
        bus.score = 32'h05F5E100;
        @(posedge clk);
        wait_done(n);
        checks++; if (n !== 34) begin failures++; $display("FAIL latency_saturated got %0d want 34", n); end
        checks++; if (bus.bcd !== 32'h99999999 || bus.overflow !== 1'b1) begin failures++; $display("FAIL sat_1e8 got bcd=%h ovf=%b want 99999999/1", bus.bcd, bus.overflow); end
        @(negedge clk);
        bus.score = 32'hFFFFFFFF;
        wait_done(n);
        checks++; if (bus.bcd !== 32'h99999999 || bus.overflow !== 1'b1 || n < 0) begin failures++; $display("FAIL sat_ffffffff got bcd=%h ovf=%b want 99999999/1", bus.bcd, bus.overflow); end
        @(negedge clk);
        bus.score = 32'd7;
        wait_done(n);
        checks++; if (bus.bcd !== 32'h00000007 || n < 0) begin failures++; $display("FAIL bcd_7 got %h want %h", bus.bcd, 32'h7); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got %b want 0", bus.overflow); end
        checks++; if (bus.blank !== 8'hFE) begin failures++; $display("FAIL blank_7 got %h want %h", bus.blank, 8'hFE); end
    endtask
    task automatic test_start();
        int n;
        int extra;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        checks++; if (n !== 34) begin failures++; $display("FAIL start_only_latency got %0d want 34", n); end
        @(negedge clk);
        bus.start = 1'b1;
        bus.score = 32'd2024;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        checks++; if (bus.bcd !== 32'h00002024 || n < 0) begin failures++; $display("FAIL start_and_auto got %h want %h", bus.bcd, 32'h2024); end
        extra = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL start_and_auto_single got %0d extra want 0", extra); end
    endtask
    task automatic test_back_to_back();
        int n;
        int extra;
        @(negedge clk);
        bus.score = 32'd42;
        @(posedge clk);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.score = 32'd43;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        checks++; if (bus.bcd !== 32'h00000042 || n < 0) begin failures++; $display("FAIL b2b_first got %h want %h", bus.bcd, 32'h42); end
        wait_done(n);
        checks++; if (n !== 35) begin failures++; $display("FAIL b2b_gap got %0d want 35", n); end
        checks++; if (bus.bcd !== 32'h00000043) begin failures++; $display("FAIL b2b_second got %h want %h", bus.bcd, 32'h43); end
        extra = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_start_queued got %0d want 0", extra); end
    endtask
    task automatic test_reset_mid();
        int n;
        int seen;
        @(negedge clk);
        bus.score = 32'd5555;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.bcd !== 32'h0) begin failures++; $display("FAIL abort_bcd got %h want %h", bus.bcd, 32'h0); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL abort_busy_done got %b%b want 00", bus.busy, bus.done); end
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        wait_done(n);
        checks++; if (n !== 34 || seen !== 0) begin failures++; $display("FAIL abort_reconvert_latency got %0d (done in reset %0d) want 34 (0)", n, seen); end
        checks++; if (bus.bcd !== 32'h00005555) begin failures++; $display("FAIL abort_reconvert got %h want %h", bus.bcd, 32'h5555); end
    endtask
    initial begin
        test_reset();
        test_latency();
        test_values();
        test_overflow();
        test_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
